// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter.
// Optional feature macro: DIV_ARB_STATS_EN (per-requester grant counters).
package div_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int STAT_W = 16;

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from pointer+1 upward,
// wrapping at NUM_REQ, and returns a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    index,
    output logic               any
);

    // Walk the requesters in rotated order; the first valid one wins.
    always_comb begin
        int idx;
        grant = '0;
        index = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(pointer) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                index      = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one multi-cycle signed divider among
// NUM_REQ requesters. One division in flight at a time; the result is
// returned tagged with the requester index.
// Optional feature macro: DIV_ARB_STATS_EN adds grant_count, a packed
// set of saturating 16-bit per-requester grant counters.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 32,
    parameter int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]  req_divisor,
    output logic                              div_valid_in,
    output logic [DIVIDEND_WIDTH-1:0]         div_dividend,
    output logic [DIVISOR_WIDTH-1:0]          div_divisor,
    input  logic [DIVIDEND_WIDTH-1:0]         div_quotient,
    input  logic [DIVISOR_WIDTH-1:0]          div_remainder,
    input  logic                              div_valid_out,
    input  logic                              div_overflow,
    output logic                              resp_valid,
    input  logic                              resp_ready,
    output logic [ID_W-1:0]                   resp_id,
    output logic [DIVIDEND_WIDTH-1:0]         resp_quotient,
    output logic [DIVISOR_WIDTH-1:0]          resp_remainder,
    output logic                              resp_overflow
`ifdef DIV_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]         grant_count
`endif
);

    state_t                    state;
    state_t                    next_state;
    logic [ID_W-1:0]           pointer;
    logic [ID_W-1:0]           id_q;
    logic [DIVIDEND_WIDTH-1:0] dividend_q;
    logic [DIVISOR_WIDTH-1:0]  divisor_q;
    logic [DIVIDEND_WIDTH-1:0] quotient_q;
    logic [DIVISOR_WIDTH-1:0]  remainder_q;
    logic                      overflow_q;
    logic [NUM_REQ-1:0]        grant;
    logic [ID_W-1:0]           grant_index;
    logic                      grant_any;
    logic                      accept;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) u_rr (
        .req    (req_valid),
        .pointer(pointer),
        .grant  (grant),
        .index  (grant_index),
        .any    (grant_any)
    );

    assign accept = (state == IDLE) && grant_any;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state and handshake outputs; grants are offered only in IDLE.
    always_comb begin
        next_state   = state;
        div_valid_in = 1'b0;
        req_ready    = '0;
        resp_valid   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = grant;
                if (grant_any) next_state = ISSUE;
            end
            ISSUE: begin
                div_valid_in = 1'b1;
                next_state   = WAIT;
            end
            WAIT: begin
                if (div_valid_out) next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture on accept, result/overflow capture while the divider runs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pointer     <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        pointer    <= grant_index;
                        id_q       <= grant_index;
                        dividend_q <= req_dividend[int'(grant_index)*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
                        divisor_q  <= req_divisor[int'(grant_index)*DIVISOR_WIDTH +: DIVISOR_WIDTH];
                        overflow_q <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (div_overflow) overflow_q <= 1'b1;
                end
                WAIT: begin
                    if (div_valid_out) begin
                        quotient_q  <= div_quotient;
                        remainder_q <= div_remainder;
                        overflow_q  <= overflow_q | div_overflow;
                    end
                end
                default: ;
            endcase
        end
    end

    // The divider keeps sampling the dividend after start, so operands stay held until it answers.
    assign div_dividend   = (state == ISSUE || state == WAIT) ? dividend_q : '0;
    assign div_divisor    = (state == ISSUE || state == WAIT) ? divisor_q  : '0;
    assign resp_id        = id_q;
    assign resp_quotient  = quotient_q;
    assign resp_remainder = remainder_q;
    assign resp_overflow  = overflow_q;

`ifdef DIV_ARB_STATS_EN
    logic [STAT_W-1:0] grant_cnt [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        // Saturating count of grants given to requester g.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                grant_cnt[g] <= '0;
            else if (accept && grant[g] && (grant_cnt[g] != {STAT_W{1'b1}}))
                grant_cnt[g] <= grant_cnt[g] + 1'b1;
        end
        assign grant_count[g*STAT_W +: STAT_W] = grant_cnt[g];
    end
`endif

endmodule
